// File: rtl/bus_cmd_pkg.sv
// rtl/bus_cmd_pkg.sv - shared state encoding, command bit positions and timeout sizing
package bus_cmd_pkg;

  typedef enum logic [2:0] {
    ST_CMD,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_DATA,
    ST_BUSY,
    ST_DRAIN,
    ST_GAP
  } state_e;

  localparam int WE_BIT  = 7;
  localparam int A16_BIT = 0;

  // The counter is loaded with TIMEOUT-1, so it only has to hold that value.
  function automatic int cnt_width(input int timeout);
    return (timeout < 3) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/bus_cmd_timeout.sv
// rtl/bus_cmd_timeout.sv - loadable down-counter with clear, enable and expired flag
module bus_cmd_timeout #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             expired
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/bus_cmd_decoder.sv
// rtl/bus_cmd_decoder.sv - host byte stream to bus access command; burst mode under BUS_CMD_AUTOINC_EN
module bus_cmd_decoder
  import bus_cmd_pkg::*;
#(
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_start,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_byte,
  output logic                  pending,
  input  logic                  done,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] bus_din,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  error
);

  localparam int CNT_W = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(TIMEOUT - 1);

  state_e                  state_q, state_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic                    rd_valid_q, rd_valid_d;
  logic                    error_q, error_d;
  logic                    pending_q, pending_d;
  logic [16:0]             addr_ext;
  logic                    tmo_load, tmo_expired;
`ifdef BUS_CMD_AUTOINC_EN
  logic [ADDR_WIDTH-1:0]   addr_inc;
  assign addr_inc = addr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
`endif

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    addr_ext  = 17'(addr_q);
    wr_data_d = wr_data_q;
    rd_data_d = rd_data_q;
    error_d   = error_q;
    if (frame_start) begin
      state_d = ST_CMD;
      error_d = 1'b0;
    end else begin
      case (state_q)
        ST_CMD: if (rx_valid) begin
          we_d         = rx_byte[WE_BIT];
          addr_ext[16] = rx_byte[A16_BIT];
          state_d      = ST_ADDR_HI;
        end
        ST_ADDR_HI: if (rx_valid) begin
          addr_ext[15:8] = rx_byte;
          state_d        = ST_ADDR_LO;
        end
        ST_ADDR_LO: if (rx_valid) begin
          addr_ext[7:0] = rx_byte;
          state_d       = we_q ? ST_DATA : ST_BUSY;
        end
        ST_DATA: if (rx_valid) begin
          wr_data_d = rx_byte;
          state_d   = ST_BUSY;
        end
        ST_BUSY: begin
          if (rx_valid) error_d = 1'b1;
          // done wins over a timeout expiring in the same cycle
          if (done) begin
            if (!we_q) rd_data_d = bus_din;
            state_d = ST_DRAIN;
          end else if (tmo_expired) begin
            error_d = 1'b1;
            state_d = ST_CMD;
          end
        end
        ST_DRAIN: begin
          if (rx_valid) error_d = 1'b1;
`ifdef BUS_CMD_AUTOINC_EN
          addr_ext = 17'(addr_inc);
          state_d  = we_q ? ST_DATA : ST_GAP;
`else
          state_d  = ST_CMD;
`endif
        end
        ST_GAP: begin
          if (rx_valid) error_d = 1'b1;
          state_d = ST_BUSY;
        end
        default: state_d = ST_CMD;
      endcase
    end
    addr_d     = addr_ext[ADDR_WIDTH-1:0];
    pending_d  = (state_d == ST_BUSY);
    rd_valid_d = (state_d == ST_DRAIN) && !we_q;
  end

  assign tmo_load = (state_d == ST_BUSY) && (state_q != ST_BUSY);

  bus_cmd_timeout #(
    .WIDTH(CNT_W)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (frame_start),
    .load    (tmo_load),
    .load_val(TMO_LOAD),
    .en      (state_q == ST_BUSY),
    .expired (tmo_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_CMD;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wr_data_q  <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      error_q    <= 1'b0;
      pending_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wr_data_q  <= wr_data_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      error_q    <= error_d;
      pending_q  <= pending_d;
    end
  end

  assign pending  = pending_q;
  assign we       = we_q;
  assign addr     = addr_q;
  assign wr_data  = wr_data_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign error    = error_q;

endmodule

// File: tb/tb_bus_cmd_decoder.sv
// tb/tb_bus_cmd_decoder.sv - directed self-checking bench for bus_cmd_decoder
module tb_bus_cmd_decoder;

  localparam int AW  = 17;
  localparam int TMO = 4;

  logic          clk = 1'b0;
  logic          reset, frame_start, rx_valid, done;
  logic [7:0]    rx_byte, bus_din;
  logic          pending, we, rd_valid, error;
  logic [AW-1:0] addr;
  logic [7:0]    wr_data, rd_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bus_cmd_decoder #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(8),
    .TIMEOUT   (TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .frame_start(frame_start),
    .rx_valid   (rx_valid),
    .rx_byte    (rx_byte),
    .pending    (pending),
    .done       (done),
    .we         (we),
    .addr       (addr),
    .wr_data    (wr_data),
    .bus_din    (bus_din),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .error      (error)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic finish_access(input logic [7:0] din);
    bus_din = din;
    done    = 1'b1;
    @(negedge clk);
    done    = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    logic [AW-1:0] exp_addr [3];
    reset = 1'b1; frame_start = 1'b0; rx_valid = 1'b0; rx_byte = '0;
    done = 1'b0; bus_din = '0;
    repeat (2) @(negedge clk);
    check("rst_pending", pending, 0);
    check("rst_we", we, 0);
    check("rst_addr", addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_error", error, 0);
    reset = 1'b0;
    tick();

    // write 0x12345 <- 0xA5
    send_byte(8'h81); send_byte(8'h23); send_byte(8'h45);
    check("wr_pending_early", pending, 0);
    send_byte(8'hA5);
    check("wr_pending", pending, 1);
    check("wr_we", we, 1);
    check("wr_addr", addr, 17'h12345);
    check("wr_data", wr_data, 8'hA5);
    tick(); check("wr_pending_c2", pending, 1);
    tick(); check("wr_pending_c3", pending, 1);
    finish_access(8'h00);
    check("wr_pending_drop", pending, 0);
    check("wr_no_rd_valid", rd_valid, 0);
    tick();
    check("wr_no_rd_valid2", rd_valid, 0);

    // read 0x08000 -> 0x5C
    send_byte(8'h00); send_byte(8'h80); send_byte(8'h00);
    check("rd_pending", pending, 1);
    check("rd_we", we, 0);
    check("rd_addr", addr, 17'h08000);
    finish_access(8'h5C);
    check("rd_valid_pulse", rd_valid, 1);
    check("rd_data", rd_data, 8'h5C);
    check("rd_pending_drop", pending, 0);
    tick();
    check("rd_valid_end", rd_valid, 0);

    // done outside BUSY is ignored
    done = 1'b1; tick(); done = 1'b0; tick();
    check("idle_done_pending", pending, 0);
    check("idle_done_rd_valid", rd_valid, 0);
    check("idle_done_rd_data", rd_data, 8'h5C);

    // timeout: pending high exactly TMO cycles
    send_byte(8'h81); send_byte(8'h00); send_byte(8'h01); send_byte(8'h77);
    cnt = 0;
    for (int i = 0; i < 20 && pending; i++) begin
      if (rd_valid) check("tmo_rd_valid", rd_valid, 0);
      cnt++;
      tick();
    end
    check("tmo_pending_cycles", cnt, TMO);
    check("tmo_error", error, 1);
    check("tmo_rd_valid_after", rd_valid, 0);
    pulse_frame();
    check("tmo_error_cleared", error, 0);

    // abort by frame_start
    send_byte(8'h00); send_byte(8'h12); send_byte(8'h34);
    check("abort_pending", pending, 1);
    check("abort_addr", addr, 17'h01234);
    pulse_frame();
    check("abort_pending_drop", pending, 0);
    check("abort_rd_valid", rd_valid, 0);
    check("abort_addr_hold", addr, 17'h01234);
    check("abort_we_hold", we, 0);
    tick();
    check("abort_rd_valid2", rd_valid, 0);
    send_byte(8'h80); send_byte(8'h00); send_byte(8'h10); send_byte(8'h3C);
    check("fresh_pending", pending, 1);
    check("fresh_we", we, 1);
    check("fresh_addr", addr, 17'h00010);
    check("fresh_wr_data", wr_data, 8'h3C);
    finish_access(8'h00);
    check("fresh_pending_drop", pending, 0);
    tick();

    // byte while busy
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h05);
    check("busy_pending", pending, 1);
    send_byte(8'hFF);
    check("busy_error", error, 1);
    check("busy_addr", addr, 17'h10005);
    check("busy_pending_hold", pending, 1);
    finish_access(8'h99);
    check("busy_rd_data", rd_data, 8'h99);
    check("busy_error_sticky", error, 1);
    tick();

    // frame_start beats a simultaneous byte
    frame_start = 1'b1; rx_valid = 1'b1; rx_byte = 8'h81;
    tick();
    frame_start = 1'b0; rx_valid = 1'b0;
    check("sim_error_cleared", error, 0);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h07);
    check("sim_pending", pending, 1);
    check("sim_we", we, 0);
    check("sim_addr", addr, 17'h00007);
    finish_access(8'hC3);
    check("sim_rd_valid", rd_valid, 1);
    check("sim_rd_data", rd_data, 8'hC3);
    tick();

`ifdef BUS_CMD_AUTOINC_EN
    // read burst across the address wrap
    exp_addr[0] = 17'h1FFFF; exp_addr[1] = 17'h00000; exp_addr[2] = 17'h00001;
    pulse_frame();
    send_byte(8'h01); send_byte(8'hFF); send_byte(8'hFF);
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 10 && !pending; i++) tick();
      check("ai_pending", pending, 1);
      check("ai_addr", addr, exp_addr[k]);
      finish_access(8'h10 + 8'(k));
      check("ai_rd_valid", rd_valid, 1);
      check("ai_rd_data", rd_data, 8'h10 + 8'(k));
    end
    pulse_frame();
    tick();
    check("ai_stop_pending", pending, 0);
`else
    exp_addr[0] = '0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
